// File: rtl/galaksija_ram_arbiter.sv
// Single-port main RAM arbiter: CPU has priority, DMA takes idle slots or a forced slot when starved.
// Optional ARB_ROM_PROTECT_EN: suppress writes at or below ROM_TOP for either owner.
module galaksija_ram_arbiter #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                STARVE_MAX = 8,
    parameter logic [ADDR_W-1:0] ROM_TOP    = 16'h1FFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait_n,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

`ifdef ARB_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               cpuStrobe;
    logic               forceSlot;
    logic               dmaOwn;
    logic               ownerWe;

    // Slot ownership and RAM mux; reset hands the slot to the CPU without side effects
    always_comb begin
        cpuStrobe  = cpu_rd | cpu_wr;
        forceSlot  = (state_q == ST_FORCE);
        dmaOwn     = reset_n & dma_req & (forceSlot | ~cpuStrobe);

        ram_addr   = cpu_addr;
        ownerWe    = cpu_wr;
        ram_wdata  = cpu_wdata;
        if (dmaOwn) begin
            ram_addr  = dma_addr;
            ownerWe   = dma_we;
            ram_wdata = dma_wdata;
        end
        ram_we     = ownerWe & ~(ROM_PROTECT & (ram_addr <= ROM_TOP));

        dma_ack    = dmaOwn;
        cpu_wait_n = ~(forceSlot & dmaOwn & cpuStrobe);
        cpu_rdata  = ram_rdata;
        dma_rvalid = rvalid_q;
        dma_rdata  = rvalid_q ? ram_rdata : rdata_q;
    end

    // Starvation tracking: a slot is forced once the DMA has waited STARVE_MAX cycles
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        rvalid_d = dmaOwn & ~dma_we;
        rdata_d  = rvalid_q ? ram_rdata : rdata_q;

        if (!dma_req || dmaOwn) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
        end

        case (state_q)
            ST_NORMAL: if (starve_d == STARVE_LIM) state_d = ST_FORCE;
            ST_FORCE:  state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_galaksija_ram_arbiter.sv
// Bench for galaksija_ram_arbiter: BRAM stand-in, per-cycle reference model and directed scenarios.
module tb_galaksija_ram_arbiter;

    localparam int STARVE_MAX = 8;
    localparam logic [15:0] ROM_TOP = 16'h1FFF;

    logic        clk;
    logic        reset_n;
    logic        cpu_rd, cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_wait_n;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        dma_ack, dma_rvalid;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    logic [7:0] bram   [0:65535];
    logic [7:0] refMem [0:65535];

    galaksija_ram_arbiter #(
        .ADDR_W(16), .DATA_W(8), .STARVE_MAX(STARVE_MAX), .ROM_TOP(ROM_TOP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] initVal(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Read-first BRAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) bram[ram_addr] <= ram_wdata;
        ram_rdata <= bram[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: how long the DMA has waited, and what the RAM read last cycle
    int         streak = 0;
    bit         pendRead = 0;
    bit         prevValid = 0;
    logic [7:0] prevRdVal = 8'h00;
    logic [7:0] lastDmaRdata = 8'h00;

    always @(negedge clk) begin
        bit         strobe, req, forced, dmaOwn, eWe, eWait;
        logic [15:0] eAddr;
        logic [7:0]  eWd;
        strobe = cpu_rd || cpu_wr;
        req    = reset_n && dma_req;
        forced = req && (streak == STARVE_MAX);
        dmaOwn = req && (forced || !strobe);
        eAddr  = dmaOwn ? dma_addr  : cpu_addr;
        eWe    = dmaOwn ? dma_we    : cpu_wr;
        eWd    = dmaOwn ? dma_wdata : cpu_wdata;
`ifdef ARB_ROM_PROTECT_EN
        if (eAddr <= ROM_TOP) eWe = 1'b0;
`endif
        eWait = !(forced && strobe);

        if (checkEn) begin
            checkOutput("ram_addr",   ram_addr,   eAddr);
            checkOutput("ram_we",     ram_we,     eWe);
            checkOutput("ram_wdata",  ram_wdata,  eWd);
            checkOutput("dma_ack",    dma_ack,    dmaOwn);
            checkOutput("cpu_wait_n", cpu_wait_n, eWait);
            checkOutput("dma_rvalid", dma_rvalid, pendRead);
            checkOutput("dma_rdata",  dma_rdata,  pendRead ? prevRdVal : lastDmaRdata);
            if (prevValid) checkOutput("cpu_rdata", cpu_rdata, prevRdVal);
        end

        if (!reset_n) lastDmaRdata = 8'h00;
        else if (pendRead) lastDmaRdata = prevRdVal;
        pendRead  = dmaOwn && !dma_we;
        prevRdVal = refMem[eAddr];
        prevValid = 1;
        if (eWe) refMem[eAddr] = eWd;
        streak = (!reset_n || !dma_req || dmaOwn) ? 0 : streak + 1;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] ca,
                                 input logic [7:0] cd, input logic req, input logic we,
                                 input logic [15:0] da, input logic [7:0] dd);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_wdata = cd;
        dma_req = req; dma_we = we; dma_addr = da; dma_wdata = dd;
    endtask

    int ackCount, waitLow, firstAck, lastAck;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            bram[i]   = initVal(16'(i));
            refMem[i] = initVal(16'(i));
        end
        reset_n = 1'b0;
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);

        // Reset
        cycle();
        cycle();
        checkEn = 1;
        repeat (3) cycle();
        atNeg();
        checkOutput("rst_wait_n", cpu_wait_n, 1);
        checkOutput("rst_ack",    dma_ack,    0);
        checkOutput("rst_rvalid", dma_rvalid, 0);
        checkOutput("rst_rdata",  dma_rdata,  0);
        cycle();
        reset_n = 1'b1;

        // DMA write then read back in idle slots
        applyStimulus(0, 0, 16'h0000, 8'h00, 1, 1, 16'h4000, 8'hA5);
        atNeg();
        checkOutput("t2_wr_ack", dma_ack, 1);
        checkOutput("t2_wr_we",  ram_we,  1);
        cycle();
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h4000, 8'h00);
        cycle();
        applyStimulus(0, 0, 16'h0000, 8'h00, 1, 0, 16'h4000, 8'h00);
        atNeg();
        checkOutput("t2_rd_ack", dma_ack, 1);
        cycle();
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h4000, 8'h00);
        atNeg();
        checkOutput("t2_rvalid", dma_rvalid, 1);
        checkOutput("t2_rdata",  dma_rdata,  8'hA5);
        cycle();
        atNeg();
        checkOutput("t2_rvalid_off", dma_rvalid, 0);
        checkOutput("t2_rdata_hold", dma_rdata,  8'hA5);
        cycle();

        // Starvation: CPU reads continuously, DMA forced every 9th cycle
        applyStimulus(1, 0, 16'h2800, 8'h00, 1, 0, 16'h4000, 8'h00);
        ackCount = 0; waitLow = 0; firstAck = 0; lastAck = 0;
        for (int i = 1; i <= 18; i++) begin
            atNeg();
            if (dma_ack) begin
                ackCount++;
                if (firstAck == 0) firstAck = i;
                lastAck = i;
            end
            if (!cpu_wait_n) waitLow++;
            cycle();
        end
        checkOutput("t3_ack_count", ackCount, 2);
        checkOutput("t3_first_ack", firstAck, 9);
        checkOutput("t3_last_ack",  lastAck,  18);
        checkOutput("t3_wait_low",  waitLow,  2);
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        cycle();

        // CPU and DMA collide without starvation: CPU first, DMA in the next idle slot
        applyStimulus(1, 0, 16'h2800, 8'h00, 1, 0, 16'h4000, 8'h00);
        atNeg();
        checkOutput("t4_cpu_ack",  dma_ack,  0);
        checkOutput("t4_cpu_addr", ram_addr, 16'h2800);
        cycle();
        applyStimulus(0, 0, 16'h2800, 8'h00, 1, 0, 16'h4000, 8'h00);
        atNeg();
        checkOutput("t4_dma_ack",  dma_ack,   1);
        checkOutput("t4_dma_addr", ram_addr,  16'h4000);
        checkOutput("t4_cpu_data", cpu_rdata, 8'h14);
        cycle();
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        atNeg();
        checkOutput("t4_rdata", dma_rdata, 8'hA5);
        cycle();

        // Write into the ROM region, then read it back
        applyStimulus(0, 0, 16'h0000, 8'h00, 1, 1, 16'h1000, 8'h55);
        atNeg();
        checkOutput("t5_ack", dma_ack, 1);
`ifdef ARB_ROM_PROTECT_EN
        checkOutput("t5_we", ram_we, 0);
`else
        checkOutput("t5_we", ram_we, 1);
`endif
        cycle();
        applyStimulus(0, 0, 16'h0000, 8'h00, 1, 0, 16'h1000, 8'h00);
        cycle();
        applyStimulus(0, 1, 16'h0010, 8'h77, 0, 0, 16'h0000, 8'h00);
        atNeg();
`ifdef ARB_ROM_PROTECT_EN
        checkOutput("t5_readback", dma_rdata, 8'h2C);
`else
        checkOutput("t5_readback", dma_rdata, 8'h55);
`endif
        cycle();
        applyStimulus(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00);
        cycle();
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        cycle();

        // Reset asserted during the forced slot
        applyStimulus(0, 1, 16'h5000, 8'h11, 1, 0, 16'h6000, 8'h00);
        repeat (8) cycle();
        reset_n = 1'b0;
        atNeg();
        checkOutput("t6_rst_ack",    dma_ack,    0);
        checkOutput("t6_rst_wait_n", cpu_wait_n, 1);
        cycle();
        reset_n = 1'b1;
        ackCount = 0; firstAck = 0;
        for (int i = 1; i <= 9; i++) begin
            atNeg();
            if (i == 1) begin
                checkOutput("t6_wait_n", cpu_wait_n, 1);
                checkOutput("t6_rvalid", dma_rvalid, 0);
            end
            if (dma_ack) begin
                ackCount++;
                if (firstAck == 0) firstAck = i;
            end
            cycle();
        end
        checkOutput("t6_ack_count", ackCount, 1);
        checkOutput("t6_first_ack", firstAck, 9);
        applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
